// File: rtl/riscv_regf_pkg.sv
// Shared types and constants for the multi-port register file and its clear sequencer.
// Holds the sequencer state encoding, default geometry and the sweep start-index helper.
package riscv_regf_pkg;

    typedef enum logic {
        REGF_IDLE  = 1'b0,
        REGF_CLEAR = 1'b1
    } regf_state_e;

    localparam int REGF_DATA_W = 32;
    localparam int REGF_ADDR_W = 5;

    // Entry 0 is skipped by the sweep when it is hardwired to zero.
    function automatic int regf_sweep_start(input int zero_reg);
        return (zero_reg != 0) ? 1 : 0;
    endfunction

endpackage

// File: rtl/riscv_regf_clr_fsm.sv
// Bulk-clear sequencer: one entry zeroed per cycle; done pulses one cycle after the last entry.
// Write port is back-pressured (wr_ready low) for the whole sweep; extra clr_req pulses are ignored.
import riscv_regf_pkg::*;

module riscv_regf_clr_fsm #(
    parameter int ADDR_W   = REGF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              clr_req,
    output logic              wr_ready,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              sweep_en,
    output logic [ADDR_W-1:0] sweep_addr
);

    localparam logic [ADDR_W-1:0] START = ADDR_W'(regf_sweep_start(ZERO_REG));
    localparam logic [ADDR_W-1:0] LAST  = '1;

    regf_state_e       r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_wr_ready;
    logic              r_busy;
    logic              r_done;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_state    <= REGF_IDLE;
            r_cnt      <= '0;
            r_wr_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                REGF_IDLE: begin
                    if (clr_req) begin
                        r_state    <= REGF_CLEAR;
                        r_cnt      <= START;
                        r_wr_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                REGF_CLEAR: begin
                    if (r_cnt == LAST) begin
                        r_state    <= REGF_IDLE;
                        r_cnt      <= '0;
                        r_wr_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= REGF_IDLE;
            endcase
        end
    end

    assign wr_ready   = r_wr_ready;
    assign clr_busy   = r_busy;
    assign clr_done   = r_done;
    assign sweep_en   = (r_state == REGF_CLEAR);
    assign sweep_addr = r_cnt;

endmodule

// File: rtl/riscv_regfile_mp.sv
// Multi-read-port register file with optional zero entry and sequenced bulk clear; reads are zero latency.
// Writes stall (wr_ready low) during a clear sweep; REGF_BYPASS_EN adds same-cycle write-to-read forwarding.
import riscv_regf_pkg::*;

module riscv_regfile_mp #(
    parameter int DATA_W   = REGF_DATA_W,
    parameter int ADDR_W   = REGF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_sweep_en;
    logic [ADDR_W-1:0] w_sweep_addr;
    logic              w_wr_keep;

    riscv_regf_clr_fsm #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_clr_fsm (
        .clk        (clk),
        .areset     (areset),
        .clr_req    (clr_req),
        .wr_ready   (wr_ready),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .sweep_en   (w_sweep_en),
        .sweep_addr (w_sweep_addr)
    );

    // Accepted writes that actually land; writes to a hardwired x0 are dropped.
    assign w_wr_keep = wr_en && wr_ready && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_sweep_en) begin
            r_mem[w_sweep_addr] <= '0;
        end else if (w_wr_keep) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_dat;

        assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            w_dat = r_mem[w_addr];
`ifdef REGF_BYPASS_EN
            if (w_wr_keep && (w_addr == wr_addr)) begin
                w_dat = wr_data;
            end
`endif
            if ((ZERO_REG != 0) && (w_addr == '0)) begin
                w_dat = '0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = w_dat;
    end

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Self-checking bench for riscv_regfile_mp: directed vectors, clear/reset corner sequences, random traffic vs model.
module tb_riscv_regfile_mp;

`ifdef REGF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        wr_ready;
    logic [4:0]  rd0 = '0, rd1 = '0;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        clr_req = 1'b0;
    logic        clr_busy, clr_done;

    logic        wr_ready_z0, clr_busy_z0, clr_done_z0;
    logic [63:0] rd_data_z0;

    assign rd_addr = {rd1, rd0};

    always #5 clk = ~clk;

    riscv_regfile_mp dut (
        .clk(clk), .areset(areset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .rd_addr(rd_addr), .rd_data(rd_data), .clr_req(clr_req),
        .clr_busy(clr_busy), .clr_done(clr_done)
    );

    riscv_regfile_mp #(.ZERO_REG(0)) dut_z0 (
        .clk(clk), .areset(areset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready_z0), .rd_addr(rd_addr), .rd_data(rd_data_z0), .clr_req(1'b0),
        .clr_busy(clr_busy_z0), .clr_done(clr_done_z0)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: array contents plus a "sweep in progress" flag and next index.
    logic [31:0] mdl_mem [32];
    bit          mdl_busy;
    int          mdl_idx;
    bit          mdl_done;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (BYP && wr_en && !mdl_busy && (a == wr_addr)) return wr_data;
        return mdl_mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl_mem[i] = 32'h0;
        mdl_busy = 1'b0;
        mdl_idx  = 0;
        mdl_done = 1'b0;
    endtask

    task automatic model_step();
        bit acc;
        bit done_n;
        acc    = wr_en && !mdl_busy;
        done_n = 1'b0;
        if (mdl_busy) begin
            mdl_mem[mdl_idx] = 32'h0;
            if (mdl_idx == 31) begin
                mdl_busy = 1'b0;
                done_n   = 1'b1;
            end else begin
                mdl_idx++;
            end
        end else if (clr_req) begin
            mdl_busy = 1'b1;
            mdl_idx  = 1;
        end
        if (acc && wr_addr != 5'd0) mdl_mem[wr_addr] = wr_data;
        mdl_done = done_n;
    endtask

    task automatic check_model();
        #1;
        check("wr_ready", {31'b0, wr_ready}, {31'b0, !mdl_busy});
        check("clr_busy", {31'b0, clr_busy}, {31'b0, mdl_busy});
        check("clr_done", {31'b0, clr_done}, {31'b0, mdl_done});
        check("rd_port0", rd_data[31:0], exp_rd(rd0));
        check("rd_port1", rd_data[63:32], exp_rd(rd1));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    typedef struct {
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int busy_c;
        int done_c;
        bit accepted;

        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  BYP ? 32'hDEADBEEF : 32'h0, 32'h0};
        tbl[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
        tbl[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
        tbl[4] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd1,  5'd31, 32'h0,        BYP ? 32'hFFFFFFFF : 32'h0};
        tbl[5] = '{1'b1, 5'd1,  32'h00000001, 5'd31, 5'd1,  32'hFFFFFFFF, BYP ? 32'h1 : 32'h0};
        tbl[6] = '{1'b0, 5'd0,  32'h0,        5'd1,  5'd31, 32'h1,        32'hFFFFFFFF};
        tbl[7] = '{1'b1, 5'd5,  32'hCAFEF00D, 5'd5,  5'd5,  BYP ? 32'hCAFEF00D : 32'hDEADBEEF,
                                                            BYP ? 32'hCAFEF00D : 32'hDEADBEEF};
        tbl[8] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd4,  32'hCAFEF00D, 32'h0};

        // Reset: every address on both ports reads zero while reset is held.
        #1 areset = 1'b0;
        model_reset();
        for (int a = 0; a < 32; a++) begin
            rd0 = 5'(a);
            rd1 = 5'(31 - a);
            #1;
            check("rst_rd0", rd_data[31:0], 32'h0);
            check("rst_rd1", rd_data[63:32], 32'h0);
            check("rst_z0", rd_data_z0[31:0] | rd_data_z0[63:32], 32'h0);
            if (a == 0) begin
                check("rst_wr_ready", {31'b0, wr_ready}, 32'h1);
                check("rst_busy", {31'b0, clr_busy}, 32'h0);
                check("rst_done", {31'b0, clr_done}, 32'h0);
            end
            @(negedge clk);
        end
        areset = 1'b1;

        // Directed write/read vectors.
        for (int i = 0; i < 9; i++) begin
            wr_en   = tbl[i].we;
            wr_addr = tbl[i].wa;
            wr_data = tbl[i].wd;
            rd0     = tbl[i].ra0;
            rd1     = tbl[i].ra1;
            check_model();
            check("vec_rd0", rd_data[31:0], tbl[i].e0);
            check("vec_rd1", rd_data[63:32], tbl[i].e1);
            tick();
        end
        wr_en = 1'b0;
        rd0 = 5'd0;
        #1;
        check("z0_addr0", rd_data_z0[31:0], 32'h12345678);
        check("z0_idle", {30'b0, wr_ready_z0, clr_busy_z0}, 32'h2);
        @(negedge clk);

        // Fill 1..31 with value=addr, then sweep.
        for (int a = 1; a < 32; a++) begin
            wr_en = 1'b1; wr_addr = 5'(a); wr_data = 32'(a);
            rd0 = 5'(a); rd1 = 5'(a - 1);
            check_model();
            tick();
        end
        wr_en = 1'b0;
        clr_req = 1'b1;
        check_model();
        tick();
        clr_req = 1'b0;
        rd0 = 5'd3; rd1 = 5'd20;
        busy_c = 0; done_c = 0;
        for (int i = 0; i < 40; i++) begin
            check_model();
            if (clr_busy) begin
                if (busy_c == 10) begin
                    check("mid_addr3", rd_data[31:0], 32'h0);
                    check("mid_addr20", rd_data[63:32], 32'd20);
                end
                check("busy_wr_ready", {31'b0, wr_ready}, 32'h0);
                busy_c++;
            end
            if (clr_done) done_c++;
            tick();
        end
        check("busy_cycles", busy_c, 32'd31);
        check("done_pulses", done_c, 32'd1);
        for (int a = 0; a < 32; a++) begin
            rd0 = 5'(a); rd1 = 5'(31 - a);
            check_model();
            check("post_clr", rd_data[31:0] | rd_data[63:32], 32'h0);
            tick();
        end

        // Held write during sweep plus a second clr_req: no restart, write lands after the sweep.
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
        check_model();
        tick();
        wr_en = 1'b0;
        clr_req = 1'b1;
        check_model();
        tick();
        clr_req = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        rd0 = 5'd7; rd1 = 5'd30;
        busy_c = 0; accepted = 1'b0;
        for (int i = 0; i < 60; i++) begin
            clr_req = (i == 5);
            check_model();
            if (clr_busy) busy_c++;
            if (wr_ready) begin
                accepted = 1'b1;
                tick();
                break;
            end
            tick();
        end
        clr_req = 1'b0;
        wr_en = 1'b0;
        check("held_accepted", {31'b0, accepted}, 32'h1);
        check("held_busy_cycles", busy_c, 32'd31);
        check_model();
        check("addr7_after", rd_data[31:0], 32'hA5A5A5A5);
        tick();

        // Reset in the middle of a sweep.
        wr_en = 1'b1; wr_addr = 5'd25; wr_data = 32'd25;
        check_model();
        tick();
        wr_en = 1'b0;
        clr_req = 1'b1;
        check_model();
        tick();
        clr_req = 1'b0;
        rd0 = 5'd25; rd1 = 5'd7;
        for (int i = 0; i < 15; i++) begin
            check_model();
            tick();
        end
        check_model();
        check("pre_rst_addr25", rd_data[31:0], 32'd25);
        areset = 1'b0;
        model_reset();
        #1;
        check("arst_busy", {31'b0, clr_busy}, 32'h0);
        check("arst_wr_ready", {31'b0, wr_ready}, 32'h1);
        check("arst_done", {31'b0, clr_done}, 32'h0);
        check("arst_addr25", rd_data[31:0], 32'h0);
        check("arst_addr7", rd_data[63:32], 32'h0);
        @(negedge clk);
        areset = 1'b1;
        for (int a = 0; a < 32; a++) begin
            rd0 = 5'(a); rd1 = 5'(31 - a);
            check_model();
            tick();
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 5'($urandom_range(0, 31));
            wr_data = $urandom;
            rd0     = 5'($urandom_range(0, 31));
            rd1     = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            clr_req = ($urandom_range(0, 29) == 0);
            check_model();
            tick();
        end
        wr_en = 1'b0;
        clr_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_regfile_mp.md
Name: riscv_regfile_mp

Overview:
Parametrised multi-read-port register file for the RISC-V core, replacing the fixed 32x32 two-port file.
- Generalised in data width, depth and number of asynchronous read ports.
- Optional hardwired-zero entry 0 (x0).
- Adds a sequenced bulk-clear engine with a busy/ready handshake, so software and debug can wipe the file without asserting global reset.
- Sits between decode (read addresses) and writeback (write port).

Parameters:
DATA_W, 32, width of each register
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes; 0 = entry 0 is an ordinary register

Ports:
clk  in  1  clock, all state updates on rising edge
areset  in  1  asynchronous active-low reset
wr_en  in  1  write request
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_ready  out  1  write accepted this cycle when wr_en && wr_ready
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W]
clr_req  in  1  single-cycle pulse requesting a bulk clear
clr_busy  out  1  clear sweep in progress
clr_done  out  1  one-cycle pulse when the sweep finishes

Behaviour:
- Reset: areset low asynchronously zeroes all entries.
  - FSM goes to IDLE, sweep counter goes to 0.
  - clr_busy=0, clr_done=0, wr_ready=1.
  - rd_data reflects the zeroed array.
- Reads: combinational, rd_data[k] = array[rd_addr[k]]; zero latency.
  - When ZERO_REG=1, address 0 always returns 0.
  - Without the optional feature, a write is visible to reads from the cycle after the accepting edge.
- Writes: performed on the rising edge when wr_en && wr_ready.
  - When ZERO_REG=1, writes to address 0 are discarded.
- FSM states are IDLE and CLEAR.
- IDLE:
  - wr_ready=1.
  - clr_req=1 -> CLEAR; counter loads START, where START = 1 if ZERO_REG else 0.
- CLEAR:
  - wr_ready=0; clr_busy=1.
  - Each cycle: array[counter] <= 0, counter increments.
  - When counter == DEPTH-1 is cleared: counter wraps to 0, state -> IDLE, clr_done pulses high for exactly that next cycle.
  - Sweep duration: DEPTH-START cycles of clr_busy (31 with defaults).
- Simultaneous wr_en and clr_req in IDLE: the write is performed (wr_ready is still 1); the sweep then zeroes that entry.
- clr_req while in CLEAR: ignored; no restart.
- wr_en while in CLEAR: not accepted, no state change. The writer must hold the request until wr_ready=1.
- Reads during CLEAR:
  - Entries already swept return 0.
  - Unswept entries return their old value.
  - The entry being cleared this cycle returns its old value.
- areset mid-sweep: immediate abort to IDLE with all entries zero; no clr_done pulse.
- No out-of-range addresses exist, since DEPTH = 2**ADDR_W.

Optional Feature:
Macro: REGF_BYPASS_EN.
- Defined:
  - Write-to-read forwarding is enabled.
  - If a write is accepted this cycle and rd_addr[k]==wr_addr, rd_data[k]=wr_data combinationally. This excludes address 0 when ZERO_REG=1.
  - Forwarding applies per port independently.
  - No forwarding in CLEAR, because no write is accepted there.
- Undefined: rd_data always reflects the stored array, as described under Behaviour.

Decomposition:
- Shared package riscv_regf_pkg:
  - FSM state typedef (REGF_IDLE, REGF_CLEAR).
  - Default DATA_W/ADDR_W constants.
  - Function computing the sweep START from ZERO_REG.
- One natural sub-module: riscv_regf_clr_fsm, which owns state, counter, clr_busy, clr_done, wr_ready and the sweep write strobe/address.
- Top level holds the array, read muxes and the bypass.

Test Plan:
- Reset then read all 32 addresses on both ports -> every rd_data = 0x00000000.
- Write 0xDEADBEEF to addr 5, same cycle read port0 addr 5:
  - Without REGF_BYPASS_EN: old value (0) this cycle, 0xDEADBEEF next cycle.
  - With REGF_BYPASS_EN: 0xDEADBEEF in the same cycle.
- Write 0x12345678 to addr 0 with ZERO_REG=1 -> reads of addr 0 stay 0. With ZERO_REG=0 -> reads return 0x12345678.
- Fill addrs 1..31 with value=addr, pulse clr_req:
  - clr_busy high 31 cycles, wr_ready low throughout, clr_done pulses once.
  - Then all reads = 0.
  - Mid-sweep at cycle 10: addr 3 reads 0, addr 20 reads 20.
- During CLEAR hold wr_en (addr 7, 0xA5A5A5A5) and pulse clr_req again:
  - No restart.
  - Write lands only after return to IDLE.
  - addr 7 reads 0xA5A5A5A5 afterwards.
- Assert areset at sweep cycle 15 with addr 25 holding 25 -> all entries 0 immediately, clr_busy=0, no clr_done pulse, wr_ready=1.
